// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller states and the scoreboard entry tracked per pipeline stage.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADR_W = 3;
    localparam int unsigned WCNT_W    = 3;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } ctrl_state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_ADR_W-1:0] adr;
        logic                 load;
        logic                 memop;
    } sb_entry_t;

    // EX/MEM result is younger than MEM/WB data, so an EX hit wins.
    function automatic fwd_sel_t fwd_select(input logic used, input logic ex_hit,
                                            input logic mem_hit);
        if (!used)   return FWD_REG;
        if (ex_hit)  return FWD_EXMEM;
        if (mem_hit) return FWD_MEMWB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of destination registers in EX/MEM/WB, with load-use
// detection and operand forwarding selects for the instruction in ID.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       squash_id,
    input  logic [2:0] rs_adr_id,
    input  logic [2:0] rt_adr_id,
    input  logic       rs_used_id,
    input  logic       rt_used_id,
    input  logic       regwrite_id,
    input  logic [2:0] regwrite_adr_id,
    input  logic       main_mem_read_id,
    input  logic       main_mem_write_id,
    output logic       mem_busy,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    sb_entry_t id_entry;
    fwd_sel_t  sel_a;
    fwd_sel_t  sel_b;
    logic      unused_wb;

    // Entry entering EX; a bubble when ID/EX is flushed.
    always_comb begin
        id_entry = '0;
        if (!squash_id) begin
            id_entry.valid = regwrite_id;
            id_entry.adr   = regwrite_adr_id;
            id_entry.load  = main_mem_read_id;
            id_entry.memop = main_mem_read_id | main_mem_write_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else if (advance) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= id_entry;
        end
    end

    always_comb begin
        mem_busy = sb_mem.memop;
        load_use = sb_ex.valid && sb_ex.load &&
                   ((rs_used_id && (rs_adr_id == sb_ex.adr)) ||
                    (rt_used_id && (rt_adr_id == sb_ex.adr)));
        sel_a = fwd_select(rs_used_id,
                           sb_ex.valid && !sb_ex.load && (sb_ex.adr == rs_adr_id),
                           sb_mem.valid && (sb_mem.adr == rs_adr_id));
        sel_b = fwd_select(rt_used_id,
                           sb_ex.valid && !sb_ex.load && (sb_ex.adr == rt_adr_id),
                           sb_mem.valid && (sb_mem.adr == rt_adr_id));
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    // WB entry needs no forwarding path: the register file writes through.
    assign unused_wb = ^sb_wb;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: memory-wait
// freeze, branch flush, load-use bubble and halt drain.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned HALT_DRAIN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rs_adr_id,
    input  logic [2:0] rt_adr_id,
    input  logic       rs_used_id,
    input  logic       rt_used_id,
    input  logic       regwrite_id,
    input  logic [2:0] regwrite_adr_id,
    input  logic       main_mem_read_id,
    input  logic       main_mem_write_id,
    input  logic       is_halt_id,
    input  logic       branch_taken_ex,
    output logic       en_pcif,
    output logic       en_ifid,
    output logic       flush_ifid,
    output logic       en_idex,
    output logic       flush_idex,
    output logic       en_exmem,
    output logic       en_memwb,
    output logic [1:0] forwardingA_controll_id,
    output logic [1:0] forwardingB_controll_id,
    output logic       halted
);

    localparam int unsigned DCNT_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LIM   = WCNT_W'(MEM_LAT - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(HALT_DRAIN - 1);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_next;
    logic              mem_busy;
    logic              load_use;
    logic              mem_freeze;
    logic              advance;
    logic              id_advance;

    // wcnt never exceeds WAIT_LIM, so inequality means "still waiting".
    assign mem_freeze = (state != HALTED) && mem_busy && (wcnt != WAIT_LIM);
    assign advance    = (state != HALTED) && !mem_freeze;
    assign id_advance = advance && !branch_taken_ex && !load_use;

    hazard_scoreboard u_sb (
        .clk               (clk),
        .reset             (reset),
        .advance           (advance),
        .squash_id         (flush_idex),
        .rs_adr_id         (rs_adr_id),
        .rt_adr_id         (rt_adr_id),
        .rs_used_id        (rs_used_id),
        .rt_used_id        (rt_used_id),
        .regwrite_id       (regwrite_id),
        .regwrite_adr_id   (regwrite_adr_id),
        .main_mem_read_id  (main_mem_read_id),
        .main_mem_write_id (main_mem_write_id),
        .mem_busy          (mem_busy),
        .load_use          (load_use),
        .fwd_a             (forwardingA_controll_id),
        .fwd_b             (forwardingB_controll_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            dcnt  <= dcnt_next;
        end
    end

    // Next state; the drain counter only moves on cycles the pipeline advances.
    always_comb begin
        state_next = state;
        wcnt_next  = '0;
        dcnt_next  = dcnt;
        if (mem_freeze) begin
            wcnt_next = wcnt + 1'b1;
        end
        case (state)
            RUN: begin
                if (is_halt_id && id_advance) begin
                    state_next = DRAIN;
                    dcnt_next  = '0;
                end
            end
            DRAIN: begin
                if (advance) begin
                    if (dcnt == DRAIN_LAST) begin
                        state_next = HALTED;
                    end else begin
                        dcnt_next = dcnt + 1'b1;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        en_pcif    = 1'b1;
        en_ifid    = 1'b1;
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        if (state == HALTED) begin
            en_pcif  = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
            halted   = 1'b1;
        end else if (mem_freeze) begin
            en_pcif  = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (branch_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            en_pcif    = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (state == DRAIN) begin
            en_pcif    = 1'b0;
            flush_ifid = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, reset-out-of-halt
// sequence, then random stimulus against a stage-queue reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int unsigned MEM_LAT    = 3;
    localparam int unsigned HALT_DRAIN = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rs_adr_id, rt_adr_id, regwrite_adr_id;
    logic       rs_used_id, rt_used_id, regwrite_id;
    logic       main_mem_read_id, main_mem_write_id, is_halt_id, branch_taken_ex;
    logic       en_pcif, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, en_memwb;
    logic [1:0] forwardingA_controll_id, forwardingB_controll_id;
    logic       halted;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT), .HALT_DRAIN(HALT_DRAIN)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rs_adr_id               (rs_adr_id),
        .rt_adr_id               (rt_adr_id),
        .rs_used_id              (rs_used_id),
        .rt_used_id              (rt_used_id),
        .regwrite_id             (regwrite_id),
        .regwrite_adr_id         (regwrite_adr_id),
        .main_mem_read_id        (main_mem_read_id),
        .main_mem_write_id       (main_mem_write_id),
        .is_halt_id              (is_halt_id),
        .branch_taken_ex         (branch_taken_ex),
        .en_pcif                 (en_pcif),
        .en_ifid                 (en_ifid),
        .flush_ifid              (flush_ifid),
        .en_idex                 (en_idex),
        .flush_idex              (flush_idex),
        .en_exmem                (en_exmem),
        .en_memwb                (en_memwb),
        .forwardingA_controll_id (forwardingA_controll_id),
        .forwardingB_controll_id (forwardingB_controll_id),
        .halted                  (halted)
    );

    typedef struct {
        logic [2:0] rs, rt, rwa;
        logic       rsu, rtu, rw, rd, wr, halt, br;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [11:0] exp;
    } vec_t;

    // Reference model: one record per occupied stage, index 0=EX 1=MEM 2=WB.
    typedef struct {
        bit       v;
        bit [2:0] a;
        bit       ld;
        bit       mo;
    } ent_t;

    ent_t pipe_q[3];
    int   stall_left;
    int   drain_left;
    bit   m_halted;

    int errors = 0;
    int checks = 0;

    vec_t tab[$];

    function automatic stim_t mk(int rs, int rt, int rsu, int rtu, int rw, int rwa,
                                 int rd, int wr, int halt, int br);
        stim_t s;
        s.rs = 3'(rs);   s.rt = 3'(rt);   s.rsu = 1'(rsu); s.rtu = 1'(rtu);
        s.rw = 1'(rw);   s.rwa = 3'(rwa); s.rd = 1'(rd);   s.wr = 1'(wr);
        s.halt = 1'(halt); s.br = 1'(br);
        return s;
    endfunction

    // {en_pcif,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex, fwdA, fwdB, halted}
    function automatic logic [11:0] e(int en, int fl, int fa, int fb, int h);
        return {5'(en), 2'(fl), 2'(fa), 2'(fb), 1'(h)};
    endfunction

    function automatic logic [11:0] obs();
        return {en_pcif, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
                forwardingA_controll_id, forwardingB_controll_id, halted};
    endfunction

    task automatic add(stim_t s, logic [11:0] x);
        vec_t v;
        v.s = s;
        v.exp = x;
        tab.push_back(v);
    endtask

    task automatic drive(stim_t s);
        rs_adr_id = s.rs;  rt_adr_id = s.rt;  rs_used_id = s.rsu; rt_used_id = s.rtu;
        regwrite_id = s.rw; regwrite_adr_id = s.rwa;
        main_mem_read_id = s.rd; main_mem_write_id = s.wr;
        is_halt_id = s.halt; branch_taken_ex = s.br;
    endtask

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b_%b_%b_%b_%b expected %b_%b_%b_%b_%b", name,
                     act[11:7], act[6:5], act[4:3], act[2:1], act[0],
                     exp[11:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    function automatic logic [1:0] fwd_of(bit used, logic [2:0] adr);
        if (!used) return 2'b00;
        if (pipe_q[0].v && !pipe_q[0].ld && pipe_q[0].a == adr) return 2'b01;
        if (pipe_q[1].v && pipe_q[1].a == adr) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit model_lu(stim_t s);
        return pipe_q[0].v && pipe_q[0].ld &&
               ((s.rsu && s.rs == pipe_q[0].a) || (s.rtu && s.rt == pipe_q[0].a));
    endfunction

    function automatic logic [11:0] model_expect(stim_t s);
        logic [4:0] en = 5'b11111;
        logic       fi = 1'b0, fx = 1'b0, h = 1'b0;
        if (m_halted) begin
            en = 5'b00000; h = 1'b1;
        end else if (stall_left > 0) begin
            en = 5'b00000;
        end else if (s.br) begin
            fi = 1'b1; fx = 1'b1;
        end else if (model_lu(s)) begin
            en = 5'b00111; fx = 1'b1;
        end else if (drain_left > 0) begin
            en = 5'b01111; fi = 1'b1;
        end
        return {en, fi, fx, fwd_of(s.rsu, s.rs), fwd_of(s.rtu, s.rt), h};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe_q[i] = '{default: 0};
        stall_left = 0;
        drain_left = -1;
        m_halted   = 1'b0;
    endtask

    task automatic model_update(stim_t s, bit rst);
        bit squash;
        if (rst) begin
            model_clear();
            return;
        end
        if (m_halted) return;
        if (stall_left > 0) begin
            stall_left--;
            return;
        end
        squash = s.br || model_lu(s);
        if (drain_left < 0 && s.halt && !squash) begin
            drain_left = HALT_DRAIN;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) begin
                m_halted   = 1'b1;
                drain_left = -1;
            end
        end
        pipe_q[2] = pipe_q[1];
        pipe_q[1] = pipe_q[0];
        if (squash) pipe_q[0] = '{default: 0};
        else        pipe_q[0] = '{s.rw, s.rwa, s.rd, s.rd | s.wr};
        stall_left = pipe_q[1].mo ? int'(MEM_LAT) - 1 : 0;
    endtask

    // Drive on negedge, compare mid-cycle, advance the model at posedge.
    task automatic run_cycle(stim_t s, bit rst, bit use_tab, logic [11:0] tab_exp, string name);
        @(negedge clk);
        drive(s);
        reset = rst;
        #2;
        check(name, obs(), use_tab ? tab_exp : model_expect(s));
        @(posedge clk);
        model_update(s, rst);
    endtask

    initial begin
        stim_t nop, ld_r1, add_r1, ld_r3, add_r3, hlt, hlt_br, st;
        int    halted_cycles;

        nop    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld_r1  = mk(2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        add_r1 = mk(1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
        st     = mk(2, 3, 1, 1, 0, 0, 0, 1, 0, 0);
        ld_r3  = mk(0, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        add_r3 = mk(3, 0, 1, 1, 1, 7, 0, 0, 0, 0);
        hlt    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        hlt_br = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        add(nop,                                   e('b11111, 'b00, 0, 0, 0));
        add(mk(2, 3, 1, 1, 1, 1, 0, 0, 0, 0),      e('b11111, 'b00, 0, 0, 0));
        add(mk(1, 5, 1, 1, 1, 4, 0, 0, 0, 0),      e('b11111, 'b00, 1, 0, 0));
        add(mk(1, 4, 1, 1, 1, 6, 0, 0, 0, 0),      e('b11111, 'b00, 2, 1, 0));
        add(ld_r1,                                 e('b11111, 'b00, 0, 0, 0));
        add(add_r1,                                e('b00111, 'b01, 0, 0, 0));
        add(add_r1,                                e('b00000, 'b00, 2, 2, 0));
        add(add_r1,                                e('b00000, 'b00, 2, 2, 0));
        add(add_r1,                                e('b11111, 'b00, 2, 2, 0));
        add(st,                                    e('b11111, 'b00, 1, 0, 0));
        add(ld_r3,                                 e('b11111, 'b00, 0, 0, 0));
        add(add_r3,                                e('b00000, 'b00, 0, 0, 0));
        add(add_r3,                                e('b00000, 'b00, 0, 0, 0));
        add(add_r3,                                e('b00111, 'b01, 0, 0, 0));
        add(add_r3,                                e('b00000, 'b00, 2, 0, 0));
        add(add_r3,                                e('b00000, 'b00, 2, 0, 0));
        add(add_r3,                                e('b11111, 'b00, 2, 0, 0));
        add(hlt_br,                                e('b11111, 'b11, 0, 0, 0));
        add(nop,                                   e('b11111, 'b00, 0, 0, 0));
        add(hlt,                                   e('b11111, 'b00, 0, 0, 0));
        add(nop,                                   e('b01111, 'b10, 0, 0, 0));
        add(nop,                                   e('b01111, 'b10, 0, 0, 0));
        add(nop,                                   e('b01111, 'b10, 0, 0, 0));
        add(nop,                                   e('b00000, 'b00, 0, 0, 1));
        add(mk(7, 7, 1, 1, 1, 7, 0, 0, 0, 0),      e('b00000, 'b00, 0, 0, 1));

        model_clear();
        drive(nop);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tab[i]) run_cycle(tab[i].s, 1'b0, 1'b1, tab[i].exp, $sformatf("vec[%0d]", i));

        // Halted until the reset edge, fully running right after it.
        @(negedge clk);
        drive(nop);
        reset = 1'b1;
        #2;
        check("halt_before_reset_edge", obs(), e('b00000, 'b00, 0, 0, 1));
        @(posedge clk);
        #1;
        check("reset_leaves_halt", obs(), e('b11111, 'b00, 0, 0, 0));
        model_clear();

        halted_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            bit    rst;
            int    op;
            op     = $urandom_range(0, 9);
            s.rs   = 3'($urandom_range(0, 3));
            s.rt   = 3'($urandom_range(0, 3));
            s.rwa  = 3'($urandom_range(0, 3));
            s.rsu  = 1'($urandom_range(0, 1));
            s.rtu  = 1'($urandom_range(0, 1));
            s.rd   = (op < 3);
            s.wr   = (op == 3 || op == 4);
            s.rw   = s.wr ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            s.halt = ($urandom_range(0, 39) == 0);
            s.br   = ($urandom_range(0, 7) == 0);
            rst    = (halted_cycles > 3) || ($urandom_range(0, 249) == 0);
            run_cycle(s, rst, 1'b0, 12'h000, $sformatf("rand[%0d]", i));
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
